// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and FSM encoding for the instruction-fetch stage
package fetch_pkg;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef enum logic [1:0] {ISSUE, WAIT, HOLD, DROP} fetch_state_t;
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register; bubble beats load, hold keeps contents
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             bubble,
  input  logic             hold,
  input  logic [31:0]      instr_in,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] pcplus4_in,
  output logic [31:0]      instr_D,
  output logic [WIDTH-1:0] pc_D,
  output logic [WIDTH-1:0] pcplus4_D,
  output logic             valid_D
);
  logic [31:0]      instr_q, instr_d;
  logic [WIDTH-1:0] pc_q, pc_d, pc4_q, pc4_d;
  logic             valid_q, valid_d, wr;
  always_comb begin
    wr      = load & ~hold & ~bubble;
    instr_d = bubble ? NOP_INSTR : wr ? instr_in : instr_q;
    valid_d = bubble ? 1'b0 : wr ? 1'b1 : valid_q;
    pc_d    = wr ? pc_in : pc_q;
    pc4_d   = wr ? pcplus4_in : pc4_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end
  assign instr_D   = instr_q;
  assign pc_D      = pc_q;
  assign pcplus4_D = pc4_q;
  assign valid_D   = valid_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, single-outstanding imem request FSM and IF/ID capture.
// FETCH_PERF_EN adds perf_fetch_cnt / perf_bubble_cnt counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_D,
  input  logic             flush_D,
  input  logic             pc_src_E,
  input  logic [WIDTH-1:0] pc_target_E,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_rvalid,
  output logic [31:0]      instr_D,
  output logic [WIDTH-1:0] pc_D,
  output logic [WIDTH-1:0] pcplus4_D,
  output logic             valid_D
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      perf_fetch_cnt,
  output logic [31:0]      perf_bubble_cnt
`endif
);
  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d, pc_plus4;
  logic [31:0]      skid_q, skid_d, ld_instr;
  logic             load, bubble, hold;
  assign pc_plus4  = pc_q + WIDTH'(4);
  assign imem_req  = (state_q == ISSUE) & ~rst & ~pc_src_E;
  assign imem_addr = pc_q;
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    skid_d   = skid_q;
    ld_instr = imem_rdata;
    load     = 1'b0;
    if (pc_src_E) begin
      pc_d    = {pc_target_E[WIDTH-1:2], 2'b00};
      state_d = ((state_q == WAIT) || (state_q == DROP)) && !imem_rvalid ? DROP : ISSUE;
    end else begin
      case (state_q)
        ISSUE: state_d = WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            // a flushed response is squashed but its slot in the stream is consumed
            if (flush_D) begin
              pc_d    = pc_plus4;
              state_d = ISSUE;
            end else if (stall_D) begin
              skid_d  = imem_rdata;
              state_d = HOLD;
            end else begin
              load    = 1'b1;
              pc_d    = pc_plus4;
              state_d = ISSUE;
            end
          end
        end
        HOLD: begin
          if (!stall_D) begin
            load     = !flush_D;
            ld_instr = skid_q;
            pc_d     = pc_plus4;
            state_d  = ISSUE;
          end
        end
        DROP: state_d = imem_rvalid ? ISSUE : DROP;
      endcase
    end
    hold   = stall_D & ~pc_src_E & ~flush_D;
    bubble = pc_src_E | flush_D | (~stall_D & ~load);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ISSUE;
      pc_q    <= RESET_PC;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      skid_q  <= skid_d;
    end
  end
  if_id_reg #(.WIDTH(WIDTH)) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .bubble    (bubble),
    .hold      (hold),
    .instr_in  (ld_instr),
    .pc_in     (pc_q),
    .pcplus4_in(pc_plus4),
    .instr_D   (instr_D),
    .pc_D      (pc_D),
    .pcplus4_D (pcplus4_D),
    .valid_D   (valid_D)
  );
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d, bubble_cnt_q, bubble_cnt_d;
  always_comb begin
    fetch_cnt_d  = fetch_cnt_q + {31'd0, load};
    bubble_cnt_d = bubble_cnt_q + {31'd0, bubble & ~stall_D};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end
  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized fetch traffic against a transaction-level model with a scoreboard
module tb_fetch_stage;
  import fetch_pkg::*;
  logic        clk = 1'b0;
  logic        rst, stall_D, flush_D, pc_src_E, imem_req, imem_rvalid, valid_D;
  logic [31:0] pc_target_E, imem_addr, imem_rdata, instr_D, pc_D, pcplus4_D;
  always #5 clk = ~clk;
  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .stall_D    (stall_D),
    .flush_D    (flush_D),
    .pc_src_E   (pc_src_E),
    .pc_target_E(pc_target_E),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_rvalid(imem_rvalid),
    .instr_D    (instr_D),
    .pc_D       (pc_D),
    .pcplus4_D  (pcplus4_D),
    .valid_D    (valid_D)
  );
  typedef struct {
    logic        chk;
    logic        req;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        v;
  } exp_t;
  exp_t q[$];
  int passed = 0, total = 0;
  // model: registered IF/ID view plus the request currently in flight
  logic [31:0] m_pc, m_buf = 0, m_instr = NOP_INSTR, m_pcd = 0, m_pc4 = 0;
  logic        m_v = 0, m_inflight = 0, m_doomed = 0, m_parked = 0, m_known = 0;
  int          due = 0, lat = 1;
  logic        stale = 0, fixed = 0;
  logic [31:0] fixed_word = 32'h0050_0093;
  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.chk) begin
        check("imem_req", {31'd0, imem_req}, {31'd0, e.req});
        if (e.req) check("imem_addr", imem_addr, e.addr);
        check("valid_D", {31'd0, valid_D}, {31'd0, e.v});
        check("instr_D", instr_D, e.instr);
        check("pc_D", pc_D, e.pc);
        check("pcplus4_D", pcplus4_D, e.pc4);
      end
    end
  end
  task automatic cycle(input logic r, input logic s, input logic f, input logic p, input logic [31:0] t);
    logic        req, have;
    logic [31:0] w, old;
    @(posedge clk);
    #1;
    rst = r; stall_D = s; flush_D = f; pc_src_E = p; pc_target_E = t;
    imem_rvalid = 0; imem_rdata = $urandom;
    if (r) begin
      if (due > 0) stale = 1;
      due = 0;
    end else if (stale) begin
      imem_rvalid = 1; stale = 0;
    end else if (due == 1) begin
      imem_rvalid = 1; due = 0;
      if (fixed) imem_rdata = fixed_word;
    end else if (due > 0) due--;
    req = !r && !m_inflight && !m_parked && !p;
    q.push_back('{m_known, req, m_pc, m_instr, m_pcd, m_pc4, m_v});
    if (req) due = (lat == 0) ? $urandom_range(1, 3) : lat;
    old = m_pc; have = 0; w = 0;
    if (r) begin
      m_pc = DEFAULT_RESET_PC; m_inflight = 0; m_doomed = 0; m_parked = 0;
      m_instr = NOP_INSTR; m_pcd = 0; m_pc4 = 0; m_v = 0; m_known = 1;
    end else if (p) begin
      m_inflight = m_inflight && !imem_rvalid; m_doomed = m_inflight; m_parked = 0;
      m_pc = t & ~32'd3; m_instr = NOP_INSTR; m_v = 0;
    end else begin
      if (m_parked) begin
        if (!s) begin m_parked = 0; m_pc += 4; have = 1; w = m_buf; end
      end else if (!m_inflight) m_inflight = 1;
      else if (imem_rvalid) begin
        m_inflight = 0;
        if (m_doomed) m_doomed = 0;
        else if (f) m_pc += 4;
        else if (s) begin m_parked = 1; m_buf = imem_rdata; end
        else begin m_pc += 4; have = 1; w = imem_rdata; end
      end
      if (f || (!s && !have)) begin m_instr = NOP_INSTR; m_v = 0; end
      else if (!s) begin m_instr = w; m_pcd = old; m_pc4 = old + 4; m_v = 1; end
    end
  endtask
  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask
  task automatic wait_inflight();
    for (int i = 0; i < 10 && !(m_inflight && !m_doomed && due > 1); i++) quiet(1);
  endtask
  initial begin
    rst = 1; stall_D = 0; flush_D = 0; pc_src_E = 0; pc_target_E = 0;
    imem_rvalid = 0; imem_rdata = 0; m_pc = DEFAULT_RESET_PC;
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    fixed = 1; lat = 1;
    quiet(8);
    lat = 3;
    quiet(16);
    lat = 2; fixed = 0;
    wait_inflight();
    cycle(0, 0, 0, 1, 32'h103);
    quiet(6);
    wait_inflight();
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0);
    quiet(4);
    cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 1, 0, 0);
    quiet(4);
    lat = 3;
    wait_inflight();
    cycle(1, 0, 0, 0, 0);
    quiet(8);
    cycle(0, 0, 0, 1, 32'hFFFF_FFFE);
    quiet(8);
    lat = 0;
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 25,
            $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 8, $urandom);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined RV32 core, feeding the decode stage.
- Holds the PC and issues one-at-a-time requests to instruction memory.
- Captures each response into the IF/ID pipeline register: instr_D, pc_D, pcplus4_D, valid_D.
- Consumes the execute-stage redirect (PCSrc/target) and the hazard unit's stall_D/flush_D.

Parameters:
WIDTH, 32, address/PC width in bits
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
stall_D  in  1  hazard unit: hold IF/ID and PC
flush_D  in  1  hazard unit: write bubble into IF/ID
pc_src_E  in  1  redirect request (taken branch / JAL / JALR)
pc_target_E  in  WIDTH  redirect target
imem_req  out  1  one-cycle request pulse to instruction memory
imem_addr  out  WIDTH  request address, equal to pc_F
imem_rdata  in  32  returned instruction word
imem_rvalid  in  1  response strobe, at least 1 cycle after imem_req
instr_D  out  32  IF/ID instruction
pc_D  out  WIDTH  IF/ID PC
pcplus4_D  out  WIDTH  IF/ID PC+4
valid_D  out  1  IF/ID holds a real instruction

Behaviour:
- Reset values:
  - pc_F = RESET_PC; state = ISSUE.
  - instr_D = NOP (32'h0000_0013); pc_D = 0; pcplus4_D = 0; valid_D = 0.
  - Skid buffer cleared; imem_req = 0 while rst = 1.
- Combinational outputs:
  - imem_req = (state==ISSUE) & ~rst & ~pc_src_E.
  - imem_addr = pc_F.
- State ISSUE:
  - Request issued; go to WAIT.
  - imem_rvalid is ignored here; this covers stale responses after a reset or drop.
- State WAIT:
  - On imem_rvalid with stall_D=0: load IF/ID with {imem_rdata, pc_F, pc_F+4, valid=1}; pc_F += 4; go to ISSUE.
  - On imem_rvalid with stall_D=1: capture imem_rdata into the skid buffer; go to HOLD.
  - With no imem_rvalid and stall_D=0: write a bubble (valid_D=0, instr_D=NOP). pc_D/pcplus4_D keep their values.
- State HOLD:
  - When stall_D falls to 0: load IF/ID from the skid buffer; pc_F += 4; go to ISSUE.
- State DROP:
  - Wait for imem_rvalid, discard the data, go to ISSUE.
  - No IF/ID write other than bubbles/flush.
- Redirect (pc_src_E=1) has the highest priority after rst, in every state:
  - pc_F <= {pc_target_E[WIDTH-1:2], 2'b00} (low bits forced to 0).
  - IF/ID gets a bubble.
  - ISSUE: imem_req is masked, so no request goes out; stays ISSUE.
  - WAIT without rvalid: go to DROP.
  - WAIT with rvalid in the same cycle: discard the data; go to ISSUE.
  - HOLD: discard the buffer; go to ISSUE.
  - DROP: stays DROP, or goes to ISSUE if rvalid arrives that cycle.
- Priority for IF/ID: rst > pc_src_E > flush_D > stall_D > normal load.
  - flush_D with stall_D writes a bubble.
  - flush_D during WAIT with rvalid discards the response and advances pc_F; flushing means the fetched instruction is squashed.
- Arithmetic: PC+4 is modulo 2^WIDTH; a wrap from 32'hFFFF_FFFC to 0 is legal.
- Latency: a response arriving the cycle after imem_req appears on instr_D one cycle later. Steady state is one instruction per 2 cycles at memory latency 1.

Optional Feature:
FETCH_PERF_EN
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_bubble_cnt[31:0], both cleared by rst.
  - perf_fetch_cnt increments on each cycle where IF/ID is loaded with valid=1.
  - perf_bubble_cnt increments on each cycle where IF/ID is loaded with valid=0 and stall_D=0.
  - Both wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package fetch_pkg:
  - NOP_INSTR = 32'h0000_0013.
  - enum fetch_state_t {ISSUE, WAIT, HOLD, DROP} (2 bits).
  - Default RESET_PC.
- Sub-module if_id_reg: IF/ID register with inputs load, bubble, hold and outputs instr_D/pc_D/pcplus4_D/valid_D.
- The FSM and PC logic stay in fetch_stage.

Test Plan:
- Reset then release, memory latency 1, rdata = 0x00500093:
  - imem_req=1, imem_addr=0 at the first post-reset cycle.
  - Two cycles later instr_D=0x00500093, pc_D=0, pcplus4_D=4, valid_D=1.
  - The next request goes to address 4.
- Memory latency 3: valid_D=0 bubbles for 3 cycles between instructions; pc_F advances only on rvalid.
- pc_src_E=1 with target 0x103 while in WAIT, response arriving 2 cycles later:
  - The response is discarded (DROP); no valid_D.
  - The next imem_addr=0x100.
- stall_D=1 for 3 cycles while the response arrives:
  - IF/ID holds its previous values; state HOLD.
  - On release, instr_D shows the buffered word and the next imem_addr = previous + 4.
- flush_D=1 asserted together with stall_D=1 → next cycle valid_D=0, instr_D=NOP.
- Assert rst while in WAIT, then imem_rvalid arrives 1 cycle after reset release → ignored; imem_addr=RESET_PC is re-requested.
